// File: rtl/uart_tx_fifo_cts.sv
// uart_tx_fifo_cts
//   Buffered, flow-controlled RS232 transmitter (8N1, LSB first). Bytes from
//   the CPU side are queued in a small FIFO and serialised on tx with an
//   internal bit-rate divider. The peer's RTS drives cts; cts=1 holds off the
//   next frame but never cuts a frame already on the line.
//
//   Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between
//   the last data bit and the stop bit (8E1, 11*CLK_DIV cycles per frame).
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   wr_data   byte to enqueue
//   wr_en     single-cycle write strobe
//   full      FIFO holds 2^FIFO_AW bytes
//   empty     FIFO holds 0 bytes
//   level     FIFO occupancy (0..2^FIFO_AW)
//   overflow  one-cycle pulse after a dropped write
//   busy      frame in progress or FIFO non-empty
//   cts       asynchronous peer flow control, 1 = hold off
//   tx        serial line, idle high
module uart_tx_fifo_cts #(
    parameter int unsigned CLK_DIV = 243,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] level,
    output logic             overflow,
    output logic             busy,
    input  logic             cts,
    output logic             tx
);

    localparam int unsigned      DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] PTR_ONE  = (FIFO_AW+1)'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------- FIFO ----------------
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [7:0]       head;
    logic             pop, wr_ok;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (FIFO_AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr[FIFO_AW-1:0]];
    // A pop on the same edge frees a slot, so a write into a full FIFO is kept.
    assign wr_ok = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            overflow <= wr_en && !wr_ok;
        end
    end

    // ---------------- cts synchroniser ----------------
    // Reset to 1 so nothing is sent until the peer has been seen ready.
    logic [1:0] cts_sync;
    logic       cts_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cts_sync <= 2'b11;
        else     cts_sync <= {cts_sync[0], cts};
    end
    assign cts_s = cts_sync[1];

    // ---------------- transmit FSM ----------------
    state_t      state, state_n;
    logic [15:0] div_cnt, div_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shreg, sh_n;
    logic        tx_n;
    logic        tick, start_ok;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_n;
`endif

    assign tick     = (div_cnt == '0);
    assign start_ok = !empty && !cts_s;
    assign busy     = (state != IDLE) || !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        tx_n    = tx;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        // Divider free-runs through every bit period of a frame.
        if (state != IDLE) div_n = tick ? DIV_LAST : div_cnt - 16'd1;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    sh_n    = head;
                    tx_n    = 1'b0;
                    div_n   = DIV_LAST;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            START: begin
                if (tick) begin
                    tx_n    = shreg[0];
                    bit_n   = 3'd7;
                    state_n = DATA;
                end
            end
            DATA: begin
                // shreg[0] is the bit currently on the line.
                if (tick) begin
                    if (bit_cnt == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                        tx_n    = par_q;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        sh_n  = {1'b0, shreg[7:1]};
                        tx_n  = shreg[1];
                        bit_n = bit_cnt - 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit to keep frames contiguous.
                if (tick) begin
                    if (start_ok) begin
                        pop     = 1'b1;
                        sh_n    = head;
                        tx_n    = 1'b0;
                        state_n = START;
`ifdef UART_TX_PARITY_EN
                        par_n   = ^head;
`endif
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_cts.sv
module tb_uart_tx_fifo_cts;

    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FR = NBITS * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       wr_data;
    logic             wr_en;
    logic             full, empty, overflow, busy, cts, tx;
    logic [FIFO_AW:0] level;

    uart_tx_fifo_cts #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .busy(busy), .cts(cts), .tx(tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_frames = 0;
    logic [7:0] exp_q[$];

    // seq: line value in time order, start bit then data LSB first.
    typedef struct {
        logic [7:0] data;
        bit [0:8]   seq;
        bit         par;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [0:10] exp_seq(input vec_t v);
        bit [0:10] e;
        e = '1;
        e[0:8] = v.seq;
`ifdef UART_TX_PARITY_EN
        e[9] = v.par;
`endif
        return e;
    endfunction

    // Scoreboard monitor: decodes every frame on tx and compares it with the
    // next expected byte. Frames cut short by reset are dropped.
    bit [0:10]  ms;
    bit         mab;
    logic [7:0] mbyte;
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
            ms  = '1;
            mab = 1'b0;
            for (int off = 1; off < FR; off++) begin
                @(negedge clk);
                if (rst) begin mab = 1'b1; break; end
                if (off % CLK_DIV == CLK_DIV / 2) ms[off / CLK_DIV] = tx;
            end
            if (mab) continue;
            for (int k = 0; k < 8; k++) mbyte[k] = ms[k+1];
            n_frames++;
            check("mon_start", int'(ms[0]), 0);
            check("mon_stop", int'(ms[NBITS-1]), 1);
`ifdef UART_TX_PARITY_EN
            check("mon_parity", int'(ms[9]), int'(^mbyte));
`endif
            if (exp_q.size() == 0) check("mon_unexpected_frame", int'(mbyte), -1);
            else check("mon_byte", int'(mbyte), int'(exp_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [7:0] d, input bit expect_sent);
        @(negedge clk);
        wr_data = d;
        wr_en   = 1'b1;
        if (expect_sent) exp_q.push_back(d);
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy && t < 1000) begin @(negedge clk); t++; end
        check(nm, int'(busy), 0);
    endtask

    // One isolated frame: latency, bit values, busy drop.
    task automatic run_vec(input vec_t v);
        bit [0:10] e;
        e = exp_seq(v);
        wr(v.data, 1'b1);
        @(negedge clk); wr_en = 1'b0;   // edge N has passed
        check("lat_level1", int'(level), 1);
        check("lat_tx_idle", int'(tx), 1);
        for (int off = 0; off <= FR; off++) begin
            @(negedge clk);
            if (off == 0) begin
                check("lat_tx_fall", int'(tx), 0);
                check("lat_level0", int'(level), 0);
            end
            if (off % CLK_DIV == CLK_DIV / 2) check("vec_bit", int'(tx), int'(e[off / CLK_DIV]));
            if (off == FR - 1) check("busy_hold", int'(busy), 1);
            if (off == FR)     check("busy_fall", int'(busy), 0);
        end
    endtask

    int  f0;
    bit  allhigh;
    bit [0:10] e2;

    initial begin
        vecs[0] = '{8'h55, 9'b0_1010_1010, 1'b0};
        vecs[1] = '{8'h07, 9'b0_1110_0000, 1'b1};
        vecs[2] = '{8'h3C, 9'b0_0011_1100, 1'b0};
        vecs[3] = '{8'hA5, 9'b0_1010_0101, 1'b0};
        vecs[4] = '{8'h80, 9'b0_0000_0001, 1'b1};

        rst = 1'b1; cts = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_level", int'(level), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven single frames
        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back frames: 0xA5 then 0x3C
        e2 = exp_seq(vecs[2]);
        wr(8'hA5, 1'b1);
        wr(8'h3C, 1'b1);
        @(negedge clk); wr_en = 1'b0;   // offset 0 of first frame
        check("b2b_first_start", int'(tx), 0);
        for (int off = 1; off <= 2 * FR; off++) begin
            @(negedge clk);
            if (off == FR - 1) check("b2b_stop", int'(tx), 1);
            if (off == FR)     check("b2b_second_start", int'(tx), 0);
            if (off > FR && (off - FR) % CLK_DIV == CLK_DIV / 2)
                check("b2b_bit", int'(tx), int'(e2[(off - FR) / CLK_DIV]));
            if (off == 2 * FR - 1) check("b2b_busy_hold", int'(busy), 1);
            if (off == 2 * FR)     check("b2b_busy_fall", int'(busy), 0);
        end

        // Full / overflow under cts hold-off
        cts = 1'b1;
        repeat (3) @(negedge clk);
        f0 = n_frames;
        for (int i = 1; i <= 4; i++) wr(8'(i), 1'b1);
        @(negedge clk); wr_en = 1'b0;
        check("full_flag", int'(full), 1);
        check("full_level", int'(level), 4);
        check("full_tx_idle", int'(tx), 1);
        check("full_ovf_quiet", int'(overflow), 0);
        wr(8'h05, 1'b0);
        @(negedge clk); wr_en = 1'b0;
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_level", int'(level), 4);
        @(negedge clk);
        check("ovf_one_cycle", int'(overflow), 0);
        cts = 1'b0;
        wait_idle("full_drain_timeout");
        check("full_frames", n_frames - f0, 4);
        check("full_queue_empty", exp_q.size(), 0);

        // cts raised mid-frame, then released
        f0 = n_frames;
        wr(8'h81, 1'b1);
        wr(8'h42, 1'b1);
        @(negedge clk); wr_en = 1'b0;   // offset 0
        allhigh = 1'b1;
        for (int off = 1; off <= 60; off++) begin
            @(negedge clk);
            if (off == 17) cts = 1'b1;          // inside data bit 3
            if (off >= FR && tx !== 1'b1) allhigh = 1'b0;
            if (off == FR + 1) check("cts_level_held", int'(level), 1);
        end
        check("cts_tx_held_high", int'(allhigh), 1);
        check("cts_first_frame", n_frames - f0, 1);
        cts = 1'b0;
        @(negedge clk); check("cts_sync_edge1", int'(tx), 1);
        @(negedge clk); check("cts_sync_edge2", int'(tx), 1);
        @(negedge clk); check("cts_resume_start", int'(tx), 0);
        wait_idle("cts_drain_timeout");
        check("cts_frames", n_frames - f0, 2);

        // Reset during data bit 5 with two bytes queued
        wr(8'hF0, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        @(negedge clk); wr_en = 1'b0;   // offset 1
        repeat (24) @(negedge clk);     // offset 25
        #1 rst = 1'b1;
        #1;
        check("mrst_tx", int'(tx), 1);
        check("mrst_empty", int'(empty), 1);
        check("mrst_level", int'(level), 0);
        check("mrst_busy", int'(busy), 0);
        exp_q.delete();
        f0 = n_frames;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        allhigh = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) allhigh = 1'b0;
        end
        check("mrst_no_frame", int'(allhigh), 1);
        check("mrst_frames", n_frames - f0, 0);

        // Traffic after reset still works
        run_vec(vecs[3]);
        check("end_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
